// File: rtl/pc_sequencer.sv
// Program counter sequencer: increment, branch, jump, call/return via a
// circular return-address stack, and trap vectoring with a fetch handshake.
module pc_sequencer #(
   parameter int unsigned    N         = 32,
   parameter logic [N-1:0]   RESET_VEC = '0,
   parameter logic [31:0]    TRAP_VEC  = 32'h0000_0080,
   parameter int unsigned    INC       = 4,
   parameter int unsigned    RAS_DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         fetch_ready,
   input  logic         stall,
   input  logic         trap,
   input  logic         ret,
   input  logic         call,
   input  logic         jump_en,
   input  logic [N-1:0] jump_target,
   input  logic         branch_en,
   input  logic [N-1:0] branch_off,
   output logic [N-1:0] pc,
   output logic         pc_valid,
   output logic         ras_empty,
   output logic         ras_full,
   output logic         ras_underflow
);

   localparam int unsigned PW = $clog2(RAS_DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [N-1:0] TRAP_PC = N'(TRAP_VEC);
   localparam logic [N-1:0] INC_N   = N'(INC);
   localparam logic [CW-1:0] CNT_MAX = CW'(RAS_DEPTH);

   typedef enum logic [1:0] {
      S_BOOT,
      S_RUN,
      S_TRAP_BUB
   } state_e;

   state_e         state_q, state_d;
   logic [N-1:0]   pc_q, pc_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [PW-1:0]  tp_q, tp_d;
   logic           uf_q, uf_d;
   logic [N-1:0]   ras_q [RAS_DEPTH];
   logic [N-1:0]   ras_d [RAS_DEPTH];

   logic [N-1:0]   pc_inc;
   logic [PW-1:0]  tp_m1;
   logic           empty;
   logic           full;

   assign pc_inc = pc_q + INC_N;
   assign tp_m1  = tp_q - PW'(1);
   assign empty  = (cnt_q == '0);
   assign full   = (cnt_q == CNT_MAX);

   // tp_q names the next free slot; the top entry sits just below it
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      cnt_d   = cnt_q;
      tp_d    = tp_q;
      uf_d    = uf_q;
      ras_d   = ras_q;
      unique case (state_q)
         S_BOOT,
         S_TRAP_BUB: state_d = S_RUN;
         S_RUN: begin
            if (trap) begin
               pc_d    = TRAP_PC;
               state_d = S_TRAP_BUB;
            end else if (ret) begin
               if (empty) begin
                  pc_d    = TRAP_PC;
                  uf_d    = 1'b1;
                  state_d = S_TRAP_BUB;
               end else begin
                  pc_d  = ras_q[tp_m1];
                  tp_d  = tp_m1;
                  cnt_d = cnt_q - CW'(1);
               end
            end else if (call) begin
               ras_d[tp_q] = pc_inc;
               tp_d        = tp_q + PW'(1);
               if (!full) cnt_d = cnt_q + CW'(1);
               pc_d        = jump_target;
            end else if (jump_en) begin
               pc_d = jump_target;
            end else if (branch_en) begin
               pc_d = pc_q + branch_off;
            end else if (stall) begin
               pc_d = pc_q;
            end else if (fetch_ready) begin
               pc_d = pc_inc;
            end
         end
         default: state_d = S_BOOT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_BOOT;
         pc_q    <= RESET_VEC;
         cnt_q   <= '0;
         tp_q    <= '0;
         uf_q    <= 1'b0;
         for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
         tp_q    <= tp_d;
         uf_q    <= uf_d;
         ras_q   <= ras_d;
      end
   end

   assign pc            = pc_q;
   assign pc_valid      = (state_q == S_RUN);
   assign ras_empty     = empty;
   assign ras_full      = full;
   assign ras_underflow = uf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table, hand sequences for the
// multi-cycle corners, then random stimulus against a queue-based model.
module tb_pc_sequencer;

   localparam logic [31:0] TRAPV = 32'h0000_0080;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        fetch_ready, stall, trap, ret, call;
   logic        jump_en, branch_en;
   logic [31:0] jump_target, branch_off;
   logic [31:0] pc;
   logic        pc_valid, ras_empty, ras_full, ras_underflow;

   int errors = 0;
   int checks = 0;

   // behavioural model: a bounded queue holds return addresses
   logic [31:0] m_pc = '0;
   logic        m_valid = 1'b0;
   logic        m_uf = 1'b0;
   logic [31:0] m_ras[$];

   always #5 clk = ~clk;

   pc_sequencer dut (
      .clk(clk), .rst(rst),
      .fetch_ready(fetch_ready), .stall(stall),
      .trap(trap), .ret(ret), .call(call),
      .jump_en(jump_en), .jump_target(jump_target),
      .branch_en(branch_en), .branch_off(branch_off),
      .pc(pc), .pc_valid(pc_valid),
      .ras_empty(ras_empty), .ras_full(ras_full),
      .ras_underflow(ras_underflow)
   );

   typedef struct {
      logic        r, fr, st, tr, rt, cl, jm;
      logic [31:0] jt;
      logic        br;
      logic [31:0] off;
      logic [31:0] e_pc;
      logic        e_v, e_emp, e_full, e_uf;
   } vec_t;

   vec_t tbl[20];

   function automatic vec_t mk(
      logic r, logic fr, logic st, logic tr, logic rt,
      logic cl, logic jm, logic [31:0] jt, logic br,
      logic [31:0] off, logic [31:0] e_pc, logic e_v,
      logic e_emp, logic e_full, logic e_uf);
      vec_t v;
      v.r = r; v.fr = fr; v.st = st; v.tr = tr;
      v.rt = rt; v.cl = cl; v.jm = jm; v.jt = jt;
      v.br = br; v.off = off; v.e_pc = e_pc;
      v.e_v = e_v; v.e_emp = e_emp;
      v.e_full = e_full; v.e_uf = e_uf;
      return v;
   endfunction

   task automatic drive(logic r, logic fr, logic st,
      logic tr, logic rt, logic cl, logic jm,
      logic [31:0] jt, logic br, logic [31:0] off);
      rst = r; fetch_ready = fr; stall = st;
      trap = tr; ret = rt; call = cl; jump_en = jm;
      jump_target = jt; branch_en = br; branch_off = off;
   endtask

   task automatic model_step();
      if (!rst) begin
         m_pc = '0; m_valid = 1'b0; m_uf = 1'b0;
         m_ras.delete();
      end else if (!m_valid) begin
         m_valid = 1'b1;
      end else if (trap) begin
         m_pc = TRAPV; m_valid = 1'b0;
      end else if (ret) begin
         if (m_ras.size() == 0) begin
            m_pc = TRAPV; m_valid = 1'b0; m_uf = 1'b1;
         end else begin
            m_pc = m_ras.pop_back();
         end
      end else if (call) begin
         m_ras.push_back(m_pc + 32'd4);
         if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
         m_pc = jump_target;
      end else if (jump_en) begin
         m_pc = jump_target;
      end else if (branch_en) begin
         m_pc = m_pc + branch_off;
      end else if (!stall && fetch_ready) begin
         m_pc = m_pc + 32'd4;
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic chk(string name, logic [31:0] act,
                      logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_all(string tag, logic [31:0] e_pc,
      logic e_v, logic e_emp, logic e_full, logic e_uf);
      chk({tag, ".pc"}, pc, e_pc);
      chk({tag, ".valid"}, 32'(pc_valid), 32'(e_v));
      chk({tag, ".empty"}, 32'(ras_empty), 32'(e_emp));
      chk({tag, ".full"}, 32'(ras_full), 32'(e_full));
      chk({tag, ".uf"}, 32'(ras_underflow), 32'(e_uf));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: timeout reached");
      $fatal(1);
   end

   initial begin
      drive(0, 0, 0, 0, 0, 0, 0, '0, 0, '0);
      // r fr st tr rt cl jm jt br off | pc v emp full uf
      tbl[0]  = mk(0,1,0,0,0,0,0,0,0,0, 32'h0,1'b0,1,0,0);
      tbl[1]  = mk(0,1,0,0,0,0,0,0,0,0, 32'h0,1'b0,1,0,0);
      tbl[2]  = mk(1,1,0,0,0,0,0,0,0,0, 32'h0,1'b1,1,0,0);
      tbl[3]  = mk(1,1,0,0,0,0,0,0,0,0, 32'h4,1,1,0,0);
      tbl[4]  = mk(1,1,0,0,0,0,0,0,0,0, 32'h8,1,1,0,0);
      tbl[5]  = mk(1,0,0,0,0,0,0,0,0,0, 32'h8,1,1,0,0);
      tbl[6]  = mk(1,0,0,0,0,0,0,0,0,0, 32'h8,1,1,0,0);
      tbl[7]  = mk(1,0,0,0,0,0,0,0,0,0, 32'h8,1,1,0,0);
      tbl[8]  = mk(1,1,1,0,0,0,0,0,0,0, 32'h8,1,1,0,0);
      tbl[9]  = mk(1,1,0,0,0,0,0,0,0,0, 32'hC,1,1,0,0);
      tbl[10] = mk(1,1,0,0,0,0,0,0,0,0, 32'h10,1,1,0,0);
      tbl[11] = mk(1,1,0,0,0,0,0,0,1,32'hFFFF_FFF0,
                   32'h0,1,1,0,0);
      tbl[12] = mk(1,1,0,0,0,0,1,32'h200,1,32'h4,
                   32'h200,1,1,0,0);
      tbl[13] = mk(1,1,0,0,0,0,1,32'hFFFF_FFFC,0,0,
                   32'hFFFF_FFFC,1,1,0,0);
      tbl[14] = mk(1,1,0,0,0,0,0,0,0,0, 32'h0,1,1,0,0);
      tbl[15] = mk(1,1,0,0,0,1,0,32'h40,0,0, 32'h40,1,0,0,0);
      tbl[16] = mk(1,1,0,1,1,1,0,32'h300,0,0, 32'h80,0,0,0,0);
      tbl[17] = mk(1,1,0,0,0,1,1,32'h500,0,0, 32'h80,1,0,0,0);
      tbl[18] = mk(1,1,0,0,0,0,0,0,0,0, 32'h84,1,0,0,0);
      tbl[19] = mk(1,1,0,0,1,0,0,0,0,0, 32'h4,1,1,0,0);

      @(negedge clk);
      for (int i = 0; i < 20; i++) begin
         drive(tbl[i].r, tbl[i].fr, tbl[i].st, tbl[i].tr,
               tbl[i].rt, tbl[i].cl, tbl[i].jm, tbl[i].jt,
               tbl[i].br, tbl[i].off);
         step();
         chk_all($sformatf("vec%0d", i), tbl[i].e_pc,
                 tbl[i].e_v, tbl[i].e_emp, tbl[i].e_full,
                 tbl[i].e_uf);
      end

      // five calls overflow the 4-deep stack
      drive(1, 1, 0, 0, 0, 0, 1, 32'h100, 0, '0);
      step();
      chk_all("jmp100", 32'h100, 1, 1, 0, 0);
      for (int k = 1; k <= 5; k++) begin
         drive(1, 1, 0, 0, 0, 1, 0,
               32'((k + 1) * 32'h100), 0, '0);
         step();
         chk_all($sformatf("call%0d", k),
                 32'((k + 1) * 32'h100), 1, 0, k >= 4, 0);
      end
      for (int k = 0; k < 4; k++) begin
         drive(1, 1, 0, 0, 1, 0, 0, '0, 0, '0);
         step();
         chk_all($sformatf("ret%0d", k),
                 32'(32'h504 - k * 32'h100), 1, k == 3, 0, 0);
      end
      drive(1, 1, 0, 0, 1, 0, 0, '0, 0, '0);
      step();
      chk_all("ret_uf", 32'h80, 0, 1, 0, 1);
      drive(1, 1, 0, 0, 0, 0, 0, '0, 0, '0);
      step();
      chk_all("uf_bub", 32'h80, 1, 1, 0, 1);
      step();
      chk_all("uf_run", 32'h84, 1, 1, 0, 1);

      // reset arriving during the trap bubble
      drive(1, 1, 0, 1, 0, 0, 0, '0, 0, '0);
      step();
      chk_all("trap2", 32'h80, 0, 1, 0, 1);
      drive(0, 1, 0, 0, 0, 0, 0, '0, 0, '0);
      step();
      chk_all("rst_mid", 32'h0, 0, 1, 0, 0);
      drive(1, 1, 0, 0, 0, 0, 0, '0, 0, '0);
      step();
      chk_all("boot2", 32'h0, 1, 1, 0, 0);
      step();
      chk_all("run2", 32'h4, 1, 1, 0, 0);

      // random stimulus against the model
      for (int i = 0; i < 3000; i++) begin
         drive($urandom_range(0, 199) != 0,
               $urandom_range(0, 3) != 0,
               $urandom_range(0, 4) == 0,
               $urandom_range(0, 15) == 0,
               $urandom_range(0, 5) == 0,
               $urandom_range(0, 5) == 0,
               $urandom_range(0, 7) == 0,
               $urandom(),
               $urandom_range(0, 5) == 0,
               $urandom());
         step();
         chk("rnd.pc", pc, m_pc);
         chk("rnd.valid", 32'(pc_valid), 32'(m_valid));
         chk("rnd.empty", 32'(ras_empty),
             32'(m_ras.size() == 0));
         chk("rnd.full", 32'(ras_full),
             32'(m_ras.size() == DEPTH));
         chk("rnd.uf", 32'(ras_underflow), 32'(m_uf));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised successor to the team's plain PC register.
- Holds the program counter and sequences it by increment, PC-relative branch, absolute jump, call and return, and trap vectoring.
- Includes a valid/ready handshake towards instruction fetch and a circular return-address stack (RAS).
- Sits between decode/execute redirect logic and the fetch stage.

Parameters:
- N, 32: PC width in bits.
- RESET_VEC, 0: PC value loaded on reset.
- TRAP_VEC, 32'h0000_0080: PC loaded on trap or RAS underflow; truncated to N bits.
- INC, 4: sequential increment.
- RAS_DEPTH, 4: return-address stack entries; power of two, at least 2.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  synchronous reset, active-low (0 = reset).
- fetch_ready  in  1  fetch accepts current pc this cycle.
- stall  in  1  hold pc, suppress sequential advance.
- trap  in  1  redirect to TRAP_VEC.
- ret  in  1  pop RAS and redirect to popped address.
- call  in  1  push pc+INC, redirect to jump_target.
- jump_en  in  1  redirect to jump_target.
- jump_target  in  N  absolute target for call/jump.
- branch_en  in  1  redirect to pc + branch_off.
- branch_off  in  N  two's-complement offset.
- pc  out  N  current program counter.
- pc_valid  out  1  pc is a valid fetch address.
- ras_empty  out  1  RAS count == 0.
- ras_full  out  1  RAS count == RAS_DEPTH.
- ras_underflow  out  1  sticky flag: ret issued with empty RAS.

Behaviour:
- Reset (rst==0 at posedge):
  - pc=RESET_VEC, pc_valid=0, state=BOOT.
  - RAS count=0, top pointer=0, ras_empty=1, ras_full=0, ras_underflow=0.
  - Reset mid-operation discards any in-flight redirect.
- State machine {BOOT, RUN, TRAP_BUB}:
  - BOOT: pc_valid=0, all redirect inputs ignored; next cycle goes to RUN, pc_valid=1, pc unchanged.
  - RUN: pc_valid=1; next-PC chosen by the priority below.
  - TRAP_BUB: entered on trap. pc=TRAP_VEC already loaded, pc_valid=0 for exactly one cycle, inputs ignored; then RUN.
- RUN priority, highest first, one action per cycle:
  1. trap: pc<=TRAP_VEC, go to TRAP_BUB. RAS untouched.
  2. ret: if RAS non-empty, pc<=top entry, pop (count-1). If empty, pc<=TRAP_VEC, ras_underflow<=1, go to TRAP_BUB.
  3. call: push pc+INC, pc<=jump_target.
  4. jump_en: pc<=jump_target.
  5. branch_en: pc<=pc+branch_off, mod 2^N.
  6. stall: pc held.
  7. fetch_ready: pc<=pc+INC, mod 2^N.
  8. Otherwise pc held; handshake not complete.
- Redirects (1-5) take effect regardless of fetch_ready or stall; they flush the current address.
- Latency: a redirect asserted in cycle t appears on pc in cycle t+1.
- Arithmetic: all adds are N-bit, carry discarded. pc 32'hFFFF_FFFC + INC gives 0.
- RAS behaviour:
  - Circular LIFO.
  - Push when full overwrites the oldest entry; count stays RAS_DEPTH and the top pointer advances.
  - Pop reads the top entry and decrements the pointer mod RAS_DEPTH.
  - call and ret in the same cycle: ret wins; no push.
- ras_underflow is sticky and clears only on reset.
- pc_valid is never 1 in BOOT or TRAP_BUB.

Test Plan:
- Reset: hold rst=0 for 2 cycles, release, fetch_ready=1 -> pc=0, pc_valid=0 for one cycle, then pc_valid=1 with pc 0, 4, 8, 12 on successive cycles.
- Handshake and stall: pc=8, fetch_ready=0 for 3 cycles -> pc stays 8. Then stall=1, fetch_ready=1 -> pc stays 8. Release stall -> pc=12.
- Branch wrap and priority: pc=0x10, branch_off=0xFFFF_FFF0 -> pc=0. Next cycle jump_en=1 (target 0x200) with branch_en=1 (off 4) -> pc=0x200.
- Call/ret with overflow: RAS_DEPTH=4; 5 calls from pcs 0x100, 0x200, 0x300, 0x400, 0x500 -> ras_full=1. Five rets return 0x504, 0x404, 0x304, 0x204 in that order; the fifth ret with empty RAS -> pc=0x80, pc_valid=0 one cycle, ras_underflow=1 and stays set.
- Trap vs others: trap=1 with ret=1 and call=1 at pc=0x40, RAS holding 1 entry -> pc=0x80, RAS count still 1, one bubble cycle, then RUN.
- Reset mid-trap: assert rst=0 during TRAP_BUB -> pc=RESET_VEC, flags cleared, BOOT bubble repeated.
